// File: rtl/led_seq_pkg.sv
// LED sequencer shared types.
// Playback modes and FSM states.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_ONCE   = 2'd0,
    MODE_LOOP   = 2'd1,
    MODE_BOUNCE = 2'd2
  } mode_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PLAY = 1'b1
  } state_e;

endpackage

// File: rtl/led_seq_if.sv
// LED sequencer control/pattern bus.
// Host drives config and writes, sequencer drives dot.
interface led_seq_if #(
  parameter int WIDTH  = 5,
  parameter int DEPTH  = 32,
  parameter int HOLD_W = 8
);
  localparam int AW = $clog2(DEPTH);

  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              st;
  logic              stop;
  logic [1:0]        mode;
  logic [AW-1:0]     len;
  logic [HOLD_W-1:0] hold;
  logic [WIDTH-1:0]  dot;
  logic              busy;
  logic              done;

  modport master (
    output wr_en, wr_addr, wr_data,
    output st, stop, mode, len, hold,
    input  dot, busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  st, stop, mode, len, hold,
    output dot, busy, done
  );

endinterface

// File: rtl/led_pat_ram.sv
// Pattern memory: sync write, async read.
// Contents survive reset on purpose.
module led_pat_ram
  import led_seq_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // write port, no reset so patterns are retained
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/led_seq.sv
// LED dot-pattern sequencer top.
// Once / loop / bounce playback with per-step hold.
module led_seq
  import led_seq_pkg::*;
#(
  parameter int WIDTH  = 5,
  parameter int DEPTH  = 32,
  parameter int HOLD_W = 8
) (
  input logic clk,
  input logic rst_n,
  led_seq_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] ONE_A = AW'(1);
  localparam logic [HOLD_W-1:0] ONE_H = HOLD_W'(1);

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [AW-1:0]     lenm1_q, lenm1_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [HOLD_W-1:0] hcnt_q, hcnt_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic              dir_q, dir_d;
  logic [WIDTH-1:0]  dot_q, dot_d;
  logic              done_q, done_d;

  logic              start;
  logic              term;
  logic              at_last;
  logic              fin;
  logic [AW-1:0]     nxt_idx;
  logic              nxt_dir;
  logic [AW-1:0]     rd_addr;
  logic [WIDTH-1:0]  rd_data;

  assign start = bus.st & ~bus.stop;
  assign rd_addr = start ? '0 : nxt_idx;

  led_pat_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (bus.wr_en),
    .waddr (bus.wr_addr),
    .wdata (bus.wr_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_ONCE;
      lenm1_q <= '0;
      hold_q  <= '0;
      hcnt_q  <= '0;
      idx_q   <= '0;
      dir_q   <= 1'b0;
      dot_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      lenm1_q <= lenm1_d;
      hold_q  <= hold_d;
      hcnt_q  <= hcnt_d;
      idx_q   <= idx_d;
      dir_q   <= dir_d;
      dot_q   <= dot_d;
      done_q  <= done_d;
    end
  end

  // next step index; len=0 wraps lenm1 to DEPTH-1
  always_comb begin
    nxt_idx = idx_q + ONE_A;
    nxt_dir = dir_q;
    at_last = (idx_q == lenm1_q);
    term    = (hcnt_q == hold_q);
    fin     = 1'b0;
    unique case (1'b1)
      mode_q == MODE_LOOP: begin
        if (at_last) nxt_idx = '0;
      end
      mode_q == MODE_BOUNCE: begin
        if (lenm1_q == '0) begin
          nxt_idx = '0;
        end else if (!dir_q) begin
          if (at_last) begin
            nxt_idx = idx_q - ONE_A;
            nxt_dir = 1'b1;
          end
        end else if (idx_q == '0) begin
          nxt_idx = ONE_A;
          nxt_dir = 1'b0;
        end else begin
          nxt_idx = idx_q - ONE_A;
        end
      end
      default: fin = at_last;
    endcase
  end

  // FSM next state; stop beats st
  always_comb begin
    state_d = state_q;
    if (bus.stop) begin
      state_d = S_IDLE;
    end else if (bus.st) begin
      state_d = S_PLAY;
    end else if (state_q == S_PLAY && term && fin) begin
      state_d = S_IDLE;
    end
  end

  // config latch, counters and dot output
  always_comb begin
    mode_d  = mode_q;
    lenm1_d = lenm1_q;
    hold_d  = hold_q;
    hcnt_d  = hcnt_q;
    idx_d   = idx_q;
    dir_d   = dir_q;
    dot_d   = dot_q;
    done_d  = 1'b0;
    if (bus.stop) begin
      hcnt_d = '0;
      idx_d  = '0;
      dir_d  = 1'b0;
      dot_d  = '0;
    end else if (bus.st) begin
      mode_d  = mode_e'(bus.mode);
      lenm1_d = bus.len - ONE_A;
      hold_d  = bus.hold;
      hcnt_d  = '0;
      idx_d   = '0;
      dir_d   = 1'b0;
      dot_d   = rd_data;
    end else if (state_q == S_PLAY) begin
      if (term) begin
        hcnt_d = '0;
        if (fin) begin
          idx_d  = '0;
          dot_d  = '0;
          done_d = 1'b1;
        end else begin
          idx_d = nxt_idx;
          dir_d = nxt_dir;
          dot_d = rd_data;
        end
      end else begin
        hcnt_d = hcnt_q + ONE_H;
      end
    end
  end

  assign bus.dot  = dot_q;
  assign bus.busy = (state_q == S_PLAY);
  assign bus.done = done_q;

endmodule

// File: tb/tb_led_seq.sv
// Directed bench for led_seq with a per-cycle
// expectation queue.
module tb_led_seq;

  typedef struct {
    logic [4:0] dot;
    logic       busy;
    logic       done;
    string      tag;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;
  exp_t sb[$];

  led_seq_if #(
    .WIDTH  (5),
    .DEPTH  (32),
    .HOLD_W (8)
  ) bus ();

  led_seq #(
    .WIDTH  (5),
    .DEPTH  (32),
    .HOLD_W (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string tag,
    input logic [7:0] obs,
    input logic [7:0] exp
  );
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(
    input logic [4:0] d,
    input logic b,
    input logic dn,
    input string tag
  );
    exp_t e;
    sb.push_back('{d, b, dn, tag});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".dot"}, 8'(bus.dot), 8'(e.dot));
    chk({e.tag, ".busy"}, 8'(bus.busy), 8'(e.busy));
    chk({e.tag, ".done"}, 8'(bus.done), 8'(e.done));
  endtask

  task automatic go(
    input logic [1:0] m,
    input logic [4:0] l,
    input logic [7:0] h
  );
    bus.st   = 1'b1;
    bus.mode = m;
    bus.len  = l;
    bus.hold = h;
  endtask

  initial begin
    n_assert    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.st      = 1'b0;
    bus.stop    = 1'b0;
    bus.mode    = '0;
    bus.len     = '0;
    bus.hold    = '0;

    cyc(0, 0, 0, "rst0");
    cyc(0, 0, 0, "rst1");
    rst_n = 1'b1;

    for (int i = 0; i < 32; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = 5'(i);
      bus.wr_data = 5'(i);
      cyc(0, 0, 0, "wr");
    end
    bus.wr_en = 1'b0;

    // once, len 0 (=32), hold 0
    go(2'd0, 5'd0, 8'd0);
    cyc(0, 1, 0, "once32");
    bus.st = 1'b0;
    for (int i = 1; i < 32; i++)
      cyc(5'(i), 1, 0, "once32");
    cyc(0, 0, 1, "once32_end");
    cyc(0, 0, 0, "once32_post");

    // once, len 4, hold 2
    go(2'd0, 5'd4, 8'd2);
    cyc(0, 1, 0, "once4h2");
    bus.st = 1'b0;
    cyc(0, 1, 0, "once4h2");
    cyc(0, 1, 0, "once4h2");
    for (int v = 1; v < 4; v++)
      for (int k = 0; k < 3; k++)
        cyc(5'(v), 1, 0, "once4h2");
    cyc(0, 0, 1, "once4h2_end");
    cyc(0, 0, 0, "once4h2_post");

    // loop, len 3, then stop
    go(2'd1, 5'd3, 8'd0);
    cyc(0, 1, 0, "loop3");
    bus.st = 1'b0;
    cyc(1, 1, 0, "loop3");
    cyc(2, 1, 0, "loop3");
    cyc(0, 1, 0, "loop3");
    cyc(1, 1, 0, "loop3");
    cyc(2, 1, 0, "loop3");
    cyc(0, 1, 0, "loop3");
    bus.stop = 1'b1;
    cyc(0, 0, 0, "loop3_stop");
    bus.stop = 1'b0;
    cyc(0, 0, 0, "loop3_idle");

    // bounce, len 4
    go(2'd2, 5'd4, 8'd0);
    cyc(0, 1, 0, "bnc4");
    bus.st = 1'b0;
    cyc(1, 1, 0, "bnc4");
    cyc(2, 1, 0, "bnc4");
    cyc(3, 1, 0, "bnc4");
    cyc(2, 1, 0, "bnc4");
    cyc(1, 1, 0, "bnc4");
    cyc(0, 1, 0, "bnc4");
    cyc(1, 1, 0, "bnc4");
    cyc(2, 1, 0, "bnc4");
    bus.stop = 1'b1;
    cyc(0, 0, 0, "bnc4_stop");
    bus.stop = 1'b0;

    // bounce, len 1 holds mem[0]
    go(2'd2, 5'd1, 8'd0);
    cyc(0, 1, 0, "bnc1");
    bus.st = 1'b0;
    for (int i = 0; i < 6; i++)
      cyc(0, 1, 0, "bnc1");
    bus.stop = 1'b1;
    cyc(0, 0, 0, "bnc1_stop");
    bus.stop = 1'b0;

    // mode 3 acts as once, len 2, hold 1
    go(2'd3, 5'd2, 8'd1);
    cyc(0, 1, 0, "m3");
    bus.st = 1'b0;
    cyc(0, 1, 0, "m3");
    cyc(1, 1, 0, "m3");
    cyc(1, 1, 0, "m3");
    cyc(0, 0, 1, "m3_end");
    cyc(0, 0, 0, "m3_post");

    // retrigger with simultaneous write
    go(2'd0, 5'd8, 8'd0);
    cyc(0, 1, 0, "retrig");
    bus.st = 1'b0;
    for (int i = 1; i < 5; i++)
      cyc(5'(i), 1, 0, "retrig");
    go(2'd0, 5'd8, 8'd0);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd2;
    bus.wr_data = 5'h1f;
    cyc(0, 1, 0, "retrig_st");
    bus.st    = 1'b0;
    bus.wr_en = 1'b0;
    cyc(1, 1, 0, "retrig");
    cyc(5'h1f, 1, 0, "retrig_wr");
    for (int i = 3; i < 8; i++)
      cyc(5'(i), 1, 0, "retrig");
    cyc(0, 0, 1, "retrig_end");
    bus.wr_en   = 1'b1;
    bus.wr_addr = 5'd2;
    bus.wr_data = 5'd2;
    cyc(0, 0, 0, "restore");
    bus.wr_en = 1'b0;

    // st and stop together
    go(2'd1, 5'd4, 8'd0);
    cyc(0, 1, 0, "ststop");
    bus.st = 1'b0;
    cyc(1, 1, 0, "ststop");
    go(2'd1, 5'd4, 8'd0);
    bus.stop = 1'b1;
    cyc(0, 0, 0, "ststop_both");
    cyc(0, 0, 0, "ststop_idle");
    bus.st   = 1'b0;
    bus.stop = 1'b0;
    cyc(0, 0, 0, "ststop_after");

    // reset mid loop play
    go(2'd1, 5'd3, 8'd0);
    cyc(0, 1, 0, "rstplay");
    bus.st = 1'b0;
    cyc(1, 1, 0, "rstplay");
    cyc(2, 1, 0, "rstplay");
    rst_n = 1'b0;
    cyc(0, 0, 0, "rstplay_rst");
    rst_n = 1'b1;
    cyc(0, 0, 0, "rstplay_idle");
    go(2'd0, 5'd3, 8'd0);
    cyc(0, 1, 0, "replay");
    bus.st = 1'b0;
    cyc(1, 1, 0, "replay");
    cyc(2, 1, 0, "replay");
    cyc(0, 0, 1, "replay_end");
    cyc(0, 0, 0, "replay_post");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/led_seq.md
# led_seq

Parametrised LED dot-pattern sequencer for the display path. It holds a DEPTH x WIDTH pattern memory that can be written at run time, and plays it onto `dot` after a start pulse. Playback supports one-shot, loop and bounce (ping-pong) modes, a programmable step length and a programmable hold time per step. It replaces the fixed 32 x 5, one-shot, one-step-per-clock player.

## Interface
- WIDTH, 5, bits per pattern entry / dot vector
- DEPTH, 32, pattern entries; power of two, >= 2; AW = $clog2(DEPTH)
- HOLD_W, 8, width of per-step hold field
- clk  in  1  clock, all logic on posedge
- rst_n  in  1  reset, synchronous, active-low
- wr_en  in  1  pattern memory write strobe
- wr_addr  in  AW  write address
- wr_data  in  WIDTH  write data
- st  in  1  start/retrigger pulse
- stop  in  1  abort playback
- mode  in  2  0 once, 1 loop, 2 bounce, 3 treated as once; sampled on accepted st
- len  in  AW  step count; 0 means DEPTH; sampled on accepted st
- hold  in  HOLD_W  extra clocks per step (step lasts hold+1 cycles); sampled on accepted st
- dot  out  WIDTH  registered pattern output, 0 when idle
- busy  out  1  high while playing
- done  out  1  one-cycle pulse on natural end of a one-shot play

## Operation
- States: IDLE, PLAY.
- IDLE: dot=0, busy=0.
- st accepted (stop low) in any state:
  - latch mode/len/hold; step index=0, hold counter=0;
  - next edge: dot=mem[0], busy=1, state PLAY.
  - st while PLAY restarts from step 0 with the new config; no done.
- PLAY: hold counter counts 0..hold. On its terminal count, advance the index and load dot=mem[new index].
  - once: after index L-1 (L = len or DEPTH) ends → dot=0, busy=0, done=1 for one cycle, IDLE.
  - loop: L-1 → 0, endless.
  - bounce: 0,1,..,L-1,L-2,..,1,0,1,..; endpoints shown once per turn; L=1 holds mem[0].
- stop high: next edge dot=0, busy=0, done=0, IDLE. stop wins over simultaneous st.
- Writes allowed in any state, sync write.
  - Write at edge k is visible to loads at edge k+1 or later.
  - The displayed dot changes only at the next step load.
- Reset (rst_n low at an edge): dot=0, busy=0, done=0, IDLE, counters 0. Pattern memory is not reset and contents are retained. Reset mid-play aborts with no done.

## Timing
- Latency st → first pattern: 1 edge.
- Step n (0-based play order) is visible from edge E0+n·(hold+1), where E0 is the st edge.
- once: busy falls and done pulses at edge E0+L·(hold+1). done is never asserted in loop/bounce.
- Index and hold counter wrap arithmetic is modulo their widths. len=0 maps to DEPTH, so the counter never exceeds DEPTH-1.

## Structure
- Package led_seq_pkg:
  - typedef enum logic [1:0] mode_e {MODE_ONCE, MODE_LOOP, MODE_BOUNCE};
  - typedef enum logic state_e {S_IDLE, S_PLAY}.
- Sub-module led_pat_ram: DEPTH x WIDTH, one sync write port, one async read port.
- Top: FSM, hold counter, step index with direction bit for bounce, output register.

## Test plan
Common setup: WIDTH=5, DEPTH=32, mem[i]=i written via wr port.
- Once, len=0, hold=0, st at E0:
  - dot = 0,1,..,31 on edges E0..E0+31;
  - at E0+32: dot=0, busy=0, done=1 for exactly one cycle.
- Once, len=4, hold=2:
  - each value 0,1,2,3 held 3 cycles;
  - done at E0+12; busy high for 12 cycles.
- Loop, len=3, hold=0:
  - dot = 0,1,2,0,1,2,0;
  - stop at E0+7 → dot=0, busy=0 at that edge, done stays 0.
- Bounce, len=4, hold=0:
  - dot = 0,1,2,3,2,1,0,1,2 across 9 edges;
  - len=1 bounce holds 0 indefinitely.
- Retrigger and write:
  - st again at E0+5 during once len=8 → dot=0 at E0+5 and sequence restarts;
  - write mem[2]=5'h1F at E0+5 → dot=31 at E0+7;
  - st and stop together → IDLE, dot=0.
- rst_n low for one edge at E0+3 of a loop play:
  - dot=0, busy=0, done=0;
  - a following st replays the retained pattern from mem[0].
